// File: rtl/renkon_pool_window_if.sv
// Bundle of the frame-control, pixel-in and window-out signals of renkon_pool_window.
// Handshake: in_en is a valid-only strobe (no ready). A pixel is consumed on every clock
// where in_en=1 while busy=1; in_en is ignored otherwise. out_en qualifies window for one cycle.
interface renkon_pool_window_if #(
  parameter int DWIDTH = 16,
  parameter int SIZEW  = 6
);
  logic                  req;
  logic [SIZEW-1:0]      img_w;
  logic [SIZEW-1:0]      img_h;
  logic [1:0]            stride;
  logic                  in_en;
  logic [DWIDTH-1:0]     pixel;
  logic                  busy;
  logic                  done;
  logic                  out_en;
  logic [9*DWIDTH-1:0]   window;
  logic [1:0]            dbg_state;

  modport master (
    output req, img_w, img_h, stride, in_en, pixel,
    input  busy, done, out_en, window, dbg_state
  );

  modport slave (
    input  req, img_w, img_h, stride, in_en, pixel,
    output busy, done, out_en, window, dbg_state
  );
endinterface

// File: rtl/renkon_pool_window.sv
// 3x3 window generator for the renkon max-pool: two line buffers plus a 3x3 shift register,
// emitting windows at a per-frame stride on a raster pixel stream.
module renkon_pool_window #(
  parameter int DWIDTH = 16,
  parameter int MAXW   = 32,
  parameter int SIZEW  = 6
) (
  input  logic               clk,
  input  logic               xrst,
  renkon_pool_window_if.slave bus
);

  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [SIZEW-1:0] ONE = SIZEW'(1);
  localparam logic [SIZEW-1:0] TWO = SIZEW'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZEW-1:0]  w_q, w_d, h_q, h_d;
  logic [SIZEW-1:0]  row_q, row_d, col_q, col_d;
  logic [1:0]        s_q, s_d, rph_q, rph_d, cph_q, cph_d;
  logic              oe_q, oe_d;

  logic [DWIDTH-1:0] lb0_q [MAXW];
  logic [DWIDTH-1:0] lb1_q [MAXW];
  logic [DWIDTH-1:0] sh_q  [9];
  logic [DWIDTH-1:0] sh_d  [9];
  logic [DWIDTH-1:0] win_q [9];
  logic [9*DWIDTH-1:0] win_flat;

  logic              consume;
  logic              last_col;
  logic              last_row;
  logic              emit;
  logic [AW-1:0]     cidx;
  logic [DWIDTH-1:0] up1;
  logic [DWIDTH-1:0] up2;

  assign consume  = (state_q == S_RUN) && bus.in_en;
  assign cidx     = col_q[AW-1:0];
  assign up1      = lb0_q[cidx];
  assign up2      = lb1_q[cidx];
  assign last_col = (col_q == (w_q - ONE));
  assign last_row = (row_q == (h_q - ONE));
  // Phase counters are only meaningful from row/col 2 onward; earlier values are masked here.
  assign emit     = (row_q >= TWO) && (col_q >= TWO) && (rph_q == 2'd0) && (cph_q == 2'd0);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    s_d     = s_q;
    row_d   = row_q;
    col_d   = col_q;
    rph_d   = rph_q;
    cph_d   = cph_q;
    oe_d    = 1'b0;
    for (int k = 0; k < 9; k++) begin
      sh_d[k] = sh_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          w_d     = bus.img_w;
          h_d     = bus.img_h;
          s_d     = (bus.stride == 2'd0) ? 2'd1 : bus.stride;
          row_d   = '0;
          col_d   = '0;
          rph_d   = 2'd0;
          cph_d   = 2'd0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.in_en) begin
          for (int r = 0; r < 3; r++) begin
            sh_d[r*3]   = sh_q[r*3+1];
            sh_d[r*3+1] = sh_q[r*3+2];
          end
          sh_d[2] = up2;
          sh_d[5] = up1;
          sh_d[8] = bus.pixel;
          oe_d    = emit;

          if (last_col) begin
            col_d = '0;
            cph_d = 2'd0;
            row_d = row_q + ONE;
            if (row_q == ONE) begin
              rph_d = 2'd0;
            end else begin
              rph_d = (rph_q == (s_q - 2'd1)) ? 2'd0 : (rph_q + 2'd1);
            end
            if (last_row) begin
              state_d = S_DONE;
            end
          end else begin
            col_d = col_q + ONE;
            if (col_q == ONE) begin
              cph_d = 2'd0;
            end else begin
              cph_d = (cph_q == (s_q - 2'd1)) ? 2'd0 : (cph_q + 2'd1);
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      s_q     <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
      rph_q   <= 2'd0;
      cph_q   <= 2'd0;
      oe_q    <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        sh_q[k]  <= '0;
        win_q[k] <= '0;
      end
      for (int i = 0; i < MAXW; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      s_q     <= s_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rph_q   <= rph_d;
      cph_q   <= cph_d;
      oe_q    <= oe_d;
      for (int k = 0; k < 9; k++) begin
        sh_q[k] <= sh_d[k];
      end
      // The emitted window is the shift register including the pixel just consumed.
      if (oe_d) begin
        for (int k = 0; k < 9; k++) begin
          win_q[k] <= sh_d[k];
        end
      end
      if (consume) begin
        lb1_q[cidx] <= up1;
        lb0_q[cidx] <= bus.pixel;
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int k = 0; k < 9; k++) begin
      win_flat[k*DWIDTH +: DWIDTH] = win_q[k];
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_en    = oe_q;
  assign bus.window    = win_flat;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/renkon_pool_window.md
Name: renkon_pool_window

Overview:
- Upstream feeder for the renkon 3x3 max-pooling unit.
- Accepts one feature-map channel as a raster-order pixel stream and buffers the two previous rows.
- Emits each complete 3x3 window (9 pixels in parallel) at a runtime-selectable stride, ready for the 9-input max stage.
- Frame geometry is latched per frame at the req handshake.

Parameters:
DWIDTH, 16, signed pixel width (two's complement, passed through untouched)
MAXW, 32, maximum image width supported by the line buffers
SIZEW, 6, width of img_w/img_h fields (must hold MAXW)

Ports:
clk  input  1  clock
xrst  input  1  asynchronous active-low reset
req  input  1  frame start pulse; latches img_w, img_h, stride
img_w  input  SIZEW  image width in pixels (1..MAXW)
img_h  input  SIZEW  image height in pixels (1..2^SIZEW-1)
stride  input  2  window stride; 0 treated as 1
in_en  input  1  pixel valid
pixel  input  DWIDTH  pixel value, raster order
busy  output  1  frame in progress
done  output  1  one-cycle pulse after last pixel of frame
out_en  output  1  window valid
window  output  9*DWIDTH  element k = row r*3+c (r=0 top, c=0 left) at [k*DWIDTH +: DWIDTH]

Behaviour:
- Reset (xrst=0, async):
  - state=IDLE; busy, done, out_en, window, row/col counters, stride phase counters and line buffers all 0.
  - Reset mid-frame abandons the frame; no done pulse is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: req=1 latches geometry (stride 0 -> 1), clears counters, goes to RUN. busy=1 from the next cycle.
  - RUN: in_en ignored outside RUN. req ignored while busy.
  - Each in_en=1 cycle consumes one pixel at (row, col), then col++; at col=img_w-1, col wraps to 0 and row++.
  - When the pixel at (img_h-1, img_w-1) is consumed, go to DONE.
  - DONE: one cycle with done=1, busy=0 on the following edge; returns to IDLE.
  - req in the DONE cycle is ignored.
- Line buffers: two rows of MAXW entries, indexed by col. On a consumed pixel:
  - lb1[col] <= lb0[col]; lb0[col] <= pixel.
  - Rows row-1 and row-2 are read before the write, in the same cycle.
- Window register: 3x3 shift.
  - Per consumed pixel, each window row shifts left one column (c0<=c1, c1<=c2).
  - New right column: {lb1[col], lb0[col], pixel} for r=0,1,2.
  - Window register is not cleared at col=0; stale left columns are never emitted because of the emit rule below.
- Emit rule: out_en=1 on the cycle after consuming pixel (row, col) iff all of:
  - row>=2 and col>=2;
  - row phase counter=0, where the phase counter resets to 0 at row 2 and counts modulo stride per row;
  - col phase counter=0, where the phase counter resets to 0 at col 2 and counts modulo stride.
- Latency: window appears 1 cycle after its bottom-right pixel.
  - window holds its value until the next emit; out_en is a single-cycle pulse per window.
- Window count per frame: ((W-3)/s+1)*((H-3)/s+1), integer division.
  - If W<3 or H<3: zero windows, but the frame still completes and done pulses.
- Gaps in in_en (any length) do not alter results or emitted content.
- No arithmetic on pixel values; sign is preserved bit-exact.
- The last window's out_en and done are asserted in the same cycle.

Test Plan:
1. Reset: assert xrst=0 mid-stream -> busy/done/out_en=0 and window=0 immediately (async). No done pulse follows.
2. 4x4, stride 1, pixel=4r+c, in_en continuous:
   - 4 windows; first = {0,1,2,4,5,6,8,9,10}, 1 cycle after pixel 10.
   - Last = {5,6,7,9,10,11,13,14,15}, with done in the same cycle.
3. 7x7, stride 2, pixel=7r+c:
   - 9 windows, top-left corners (0,0),(0,2),(0,4),(2,0)..(4,4).
   - Last window element 0 = 32, element 8 = 48.
4. 6x6, stride 3, in_en toggling 1/0 plus random 0-5 cycle gaps -> 4 windows with top-left corners (0,0),(0,3),(3,0),(3,3), identical contents to the gapless run.
5. MAXW=32 width, 3 rows, stride 0, pixels negative (-1-c-32r):
   - 30 windows; stride treated as 1; sign bits intact.
   - A req pulsed mid-frame is ignored.
6. 2x5 frame -> no out_en; done after the 10th pixel.
   - Then a 3x3 frame with stride 2 -> exactly one window = pixels 0..8 in order.
